// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between NUM_REQ requesters, one op in flight.
// Define ALU_ARB_OPCHECK_EN to reject illegal opcodes with resp_err instead of issuing them.
module alu_arbiter #(
    parameter int unsigned WIDTH       = 48,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]     req_op,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [3:0]               alu_control,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic                     alu_zero,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_result,
    output logic                     resp_zero,
    output logic                     resp_err,
    output logic                     busy
);

    localparam int unsigned CntW = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_pend_q, err_pend_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]        alu_ctl_q, alu_ctl_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [WIDTH-1:0]  resp_result_q, resp_result_d;
    logic              resp_zero_q, resp_zero_d;
    logic              resp_err_q, resp_err_d;

    logic              hi_found, lo_found, grant_found;
    logic [ID_W-1:0]   hi_idx, lo_idx, grant_idx;
    logic [WIDTH-1:0]  sel_a, sel_b;
    logic [3:0]        sel_op;
    logic              op_legal;
    logic [NUM_REQ-1:0] ready_raw;

    // Requesters above rr_q take priority over those at or below it; lowest index wins in each half.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (ID_W'(i) > rr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(i);
                end
            end
        end
        grant_found = hi_found | lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_idx) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_op = req_op[i*4 +: 4];
            end
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    always_comb begin
        unique case (sel_op)
            4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC: op_legal = 1'b1;
            default:                             op_legal = 1'b0;
        endcase
    end
`else
    assign op_legal = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;
        err_pend_d    = err_pend_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_ctl_d     = alu_ctl_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
        resp_err_d    = resp_err_q;
        ready_raw     = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    ready_raw = NUM_REQ'(1) << grant_idx;
                    rr_d      = grant_idx;
                    resp_id_d = grant_idx;
                    state_d   = StExec;
                    if (op_legal) begin
                        alu_a_d    = sel_a;
                        alu_b_d    = sel_b;
                        alu_ctl_d  = sel_op;
                        cnt_d      = CntW'(ALU_LATENCY);
                        err_pend_d = 1'b0;
                    end else begin
                        // Rejected op: no ALU wait, respond on the next edge.
                        cnt_d      = '0;
                        err_pend_d = 1'b1;
                    end
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                    if (err_pend_q) begin
                        resp_result_d = '0;
                        resp_zero_d   = 1'b0;
                        resp_err_d    = 1'b1;
                    end else begin
                        resp_result_d = alu_result;
                        resp_zero_d   = alu_zero;
                        resp_err_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            rr_q          <= ID_W'(NUM_REQ - 1);
            cnt_q         <= '0;
            err_pend_q    <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctl_q     <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            err_pend_q    <= err_pend_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctl_q     <= alu_ctl_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
            resp_err_q    <= resp_err_d;
        end
    end

    // req_ready is combinational, so hold it low explicitly while reset is asserted.
    assign req_ready   = rst ? '0 : ready_raw;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_ctl_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp_err    = resp_err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner cases and random traffic
// against a round-robin reference model; the bench also plays the 1-cycle-latency ALU.
module tb_alu_arbiter;

    localparam int W   = 48;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N*4-1:0]   req_op = '0;
    logic [W-1:0]     alu_a, alu_b, alu_result;
    logic [3:0]       alu_control;
    logic             alu_zero;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [IDW-1:0]   resp_id;
    logic [W-1:0]     resp_result;
    logic             resp_zero, resp_err, busy;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IDW), .ALU_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err), .busy(busy)
    );

    function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] op);
        case (op)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h6:    return a - b;
            4'h7:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'hC:    return ~(a | b);
            default: return '0;
        endcase
    endfunction

    function automatic bit ctl_updates(input logic [3:0] op);
`ifdef ALU_ARB_OPCHECK_EN
        return op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
`else
        return 1'b1;
`endif
    endfunction

    // External ALU: result registered one edge after its inputs.
    logic [W-1:0] alu_res_q;
    always @(posedge clk) alu_res_q <= ref_res(alu_a, alu_b, alu_control);
    assign alu_result = alu_res_q;
    assign alu_zero   = (alu_res_q == '0);

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] model_ctl = 4'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One op from a single requester; hold = cycles resp_ready stays low after resp_valid.
    task automatic run_op(input string name, input int id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [3:0] op,
                          input logic [W-1:0] exp_res, input logic exp_zero,
                          input logic exp_err, input int exp_lat, input int hold);
        int lat;
        logic [N-1:0] exp_rdy;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_op[id*4 +: 4] = op;
        req_valid = '0;
        req_valid[id] = 1'b1;
        exp_rdy = '0;
        exp_rdy[id] = 1'b1;
        #1 check({name, "_grant"}, req_ready, exp_rdy);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        if (ctl_updates(op)) model_ctl = op;
        check({name, "_ctl"}, alu_control, model_ctl);
        check({name, "_busy"}, busy, 1'b1);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_id"}, resp_id, id);
        check({name, "_res"}, resp_result, exp_res);
        check({name, "_zero"}, resp_zero, exp_zero);
        check({name, "_err"}, resp_err, exp_err);
        for (int k = 0; k < hold; k++) begin
            req_valid[(id + 1) % N] = 1'b1;
            #1 check({name, "_hold_rdy"}, req_ready, 0);
            @(negedge clk);
            check({name, "_hold"}, {resp_valid, resp_id, resp_result},
                  {1'b1, IDW'(id), exp_res});
        end
        req_valid = '0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check({name, "_idle"}, {busy, resp_valid}, 2'b00);
    endtask

    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0] op;
        logic [W-1:0] res;
        logic       zero;
    } vec_t;

    vec_t vecs[6];
    int grants[$];
    int gcyc[$];
    logic [W-1:0] results[$];
    logic [W-1:0] ra[N], rb[N];
    logic [3:0]   rop[N];
    logic [3:0]   legal_ops[6];

    initial begin
        int cyc, last, w, stale, d;
        logic [N-1:0] mask, exp_rdy;
        logic [63:0] tmp;

        vecs[0] = '{0, 48'hAAAA_AAAA_AAAA, 48'h5555_5555_5555, 4'hC, 48'h0, 1'b1};
        vecs[1] = '{1, 48'd3, 48'd5, 4'h7, 48'd1, 1'b0};
        vecs[2] = '{2, 48'd0, 48'hFFFF_FFFF_FFFF, 4'h1, 48'hFFFF_FFFF_FFFF, 1'b0};
        vecs[3] = '{3, 48'd7, 48'd7, 4'h6, 48'd0, 1'b1};
        vecs[4] = '{1, 48'hF0F0, 48'h0FF0, 4'h0, 48'h00F0, 1'b0};
        vecs[5] = '{0, 48'hFFFF_FFFF_FFFF, 48'd1, 4'h7, 48'd1, 1'b0};
        legal_ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};

        // Reset state, with a pending request that must not be granted.
        req_valid = 4'b0010;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_resp", {resp_valid, resp_id, resp_result, resp_zero, resp_err}, 0);
        check("rst_alu", {alu_a, alu_control}, 0);
        check("rst_alub", alu_b, 0);
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);

        // Round-robin with all requesters continuously valid.
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(i + 1);
            req_b[i*W +: W] = W'(1);
            req_op[i*4 +: 4] = 4'h2;
        end
        resp_ready = 1'b1;
        req_valid = '1;
        cyc = 0;
        while ((grants.size() < 5 || results.size() < 4) && cyc < 60) begin
            #1;
            if (req_ready != 0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
                gcyc.push_back(cyc);
            end
            if (resp_valid) results.push_back(resp_result);
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        repeat (6) @(negedge clk);
        resp_ready = 1'b0;
        model_ctl = 4'h2;
        check("rr_ngrant", grants.size() >= 5, 1);
        check("rr_nres", results.size() >= 4, 1);
        for (int k = 0; k < 5 && k < grants.size(); k++) check("rr_order", grants[k], k % N);
        for (int k = 1; k < 5 && k < gcyc.size(); k++)
            check("rr_interval", gcyc[k] - gcyc[k-1], 4);
        for (int k = 0; k < 4 && k < results.size(); k++) check("rr_res", results[k], k + 2);

        for (int v = 0; v < 6; v++)
            run_op("vec", vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].res,
                   vecs[v].zero, 1'b0, 2, 0);

        run_op("bp", 2, 48'd10, 48'd5, 4'h6, 48'd5, 1'b0, 1'b0, 2, 5);

`ifdef ALU_ARB_OPCHECK_EN
        run_op("illop", 1, 48'd9, 48'd4, 4'h3, 48'd0, 1'b0, 1'b1, 1, 0);
`else
        run_op("illop", 1, 48'd9, 48'd4, 4'h3, 48'd0, 1'b1, 1'b0, 2, 0);
`endif

        // Reset during EXEC drops the op.
        req_a[2*W +: W] = 48'd100;
        req_b[2*W +: W] = 48'd1;
        req_op[2*4 +: 4] = 4'h2;
        req_valid = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0010;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_out", {busy, resp_valid, resp_id, resp_result, resp_err}, 0);
        check("mid_rst_alu", {alu_a, alu_control}, 0);
        model_ctl = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        req_valid = '1;
        #1 check("post_rst_winner", req_ready, 4'b0001);
        req_valid = '0;
        stale = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid || busy) stale++;
        end
        check("no_stale_resp", stale, 0);

        // Random traffic against the round-robin model (rr pointer still at N-1).
        last = N - 1;
        for (int it = 0; it < 30; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                tmp = {$urandom(), $urandom()};
                ra[i] = tmp[W-1:0];
                tmp = {$urandom(), $urandom()};
                rb[i] = tmp[W-1:0];
                if ($urandom_range(0, 3) == 0) rb[i] = ra[i];
                rop[i] = legal_ops[$urandom_range(0, 5)];
                req_a[i*W +: W] = ra[i];
                req_b[i*W +: W] = rb[i];
                req_op[i*4 +: 4] = rop[i];
            end
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && mask[(last + k) % N]) w = (last + k) % N;
            exp_rdy = '0;
            exp_rdy[w] = 1'b1;
            req_valid = mask;
            #1 check("rand_grant", req_ready, exp_rdy);
            @(posedge clk);
            @(negedge clk);
            req_valid = '0;
            last = w;
            cyc = 0;
            while (!resp_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check("rand_lat", cyc, 2);
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            check("rand_id", resp_id, w);
            check("rand_res", resp_result, ref_res(ra[w], rb[w], rop[w]));
            check("rand_zero", resp_zero, ref_res(ra[w], rb[w], rop[w]) == '0);
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 48-bit ALU (4-bit control: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, C NOR) between NUM_REQ requesters using round-robin arbitration.
- Each requester has its own valid/ready request port carrying a, b and opcode.
- The block latches the granted operands into the ALU input registers and waits out the ALU pipeline latency.
- It captures result and zero, then returns them with the requester ID on a single valid/ready response port; at most one op is in flight.

Parameters:
- WIDTH, 48, operand/result width
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of resp_id, >= clog2(NUM_REQ)
- ALU_LATENCY, 1, clock edges from ALU inputs registered to alu_result valid (0 = combinational ALU)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- req_op  in  NUM_REQ*4  ALU control code, requester i at [i*4 +: 4]
- alu_a  out  WIDTH  registered operand A to ALU
- alu_b  out  WIDTH  registered operand B to ALU
- alu_control  out  4  registered control to ALU
- alu_result  in  WIDTH  ALU result
- alu_zero  in  1  ALU zero flag
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  ID_W  index of requester that issued the op
- resp_result  out  WIDTH  captured result
- resp_zero  out  1  captured zero flag
- resp_err  out  1  illegal opcode flag (see Optional Feature)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=NUM_REQ-1, cnt=0; all outputs 0 (req_ready, alu_a/b/control, resp_*, busy). Asserting reset mid-op drops the in-flight op; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner g = first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready[g]=1, combinational from req_valid and rr_ptr; all other bits 0. No valid request -> req_ready=0.
  - On the edge where the handshake fires: alu_a/alu_b/alu_control <= operands of g; resp_id <= g; rr_ptr <= g; cnt <= ALU_LATENCY; state <= EXEC.
- EXEC: each edge, if cnt==0, capture resp_result <= alu_result, resp_zero <= alu_zero, resp_err <= 0, resp_valid <= 1, state <= RESP; otherwise cnt <= cnt-1.
- Latency: resp_valid rises ALU_LATENCY+1 edges after the request handshake edge (2 for default).
- RESP:
  - resp_valid and all resp_* held stable until resp_ready=1.
  - On that edge: resp_valid <= 0, state <= IDLE.
  - req_ready=0 in EXEC and RESP; requests are not accepted until IDLE.
- Minimum issue interval is ALU_LATENCY+3 cycles with resp_ready tied high.
- alu_a/alu_b/alu_control hold their last values outside a grant edge.
- req_valid may drop without handshake; the arbiter re-evaluates each IDLE cycle. Only a completed handshake advances rr_ptr.
- A requester must not change req_a/req_b/req_op while req_valid=1 and not granted.

Optional Feature:
- Macro: ALU_ARB_OPCHECK_EN. Legal codes are {0,1,2,6,7,C}.
- Defined: on a grant with an illegal opcode, ALU inputs are not updated and the EXEC wait is skipped. Next edge: state <= RESP, resp_valid <= 1, resp_err <= 1, resp_result <= 0, resp_zero <= 0, resp_id <= g, rr_ptr <= g.
- Undefined: opcode is passed to the ALU unchecked; resp_err is constant 0.

Test Plan:
- Single op: req_valid[0], a=48'hAAAA_AAAA_AAAA, b=48'h5555_5555_5555, op=C -> req_ready[0] one cycle; resp_valid 2 edges later; resp_id=0, resp_result=0, resp_zero=1.
- Round-robin: all 4 requesters valid continuously (req i: a=i+1, b=1, op=2), resp_ready=1 -> grant order 0,1,2,3,0; results 2,3,4,5; interval 4 cycles.
- Backpressure: SUB a=10, b=5 from req 2, resp_ready=0 for 5 cycles -> resp_valid/resp_result=5/resp_id=2 held stable; req_ready all 0 until accepted; IDLE one edge after resp_ready=1.
- SLT and OR: a=3, b=5, op=7 -> result 1, zero 0; a=0, b=48'hFFFF_FFFF_FFFF, op=1 -> result all ones, zero 0.
- Reset mid-op: assert rst during EXEC -> all outputs 0 immediately; after release, req 0 wins first when all requesters are valid; no stale response.
- With ALU_ARB_OPCHECK_EN: op=3 from req 1 -> resp_valid 1 edge after grant, resp_err=1, resp_result=0, alu_control unchanged; without the macro, op=3 reaches alu_control and resp_err=0.
